// File: rtl/csr_regfile_if.sv
// rtl/csr_regfile_if.sv - writeback-stage CSR access and exception-commit bundle
interface csr_regfile_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        has_int;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  csr_rvalue, csr_eentry, csr_era, has_int
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output csr_rvalue, csr_eentry, csr_era, has_int
  );
endinterface

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - LoongArch CSR file with exception commit, stable timer and interrupt flag
module csr_regfile #(
  parameter logic [31:0] TID_RESET = 32'h0,
  parameter int          TIMER_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  csr_regfile_if.slave      bus,
  input  logic [7:0]        hw_int_in,
  input  logic              ipi_int_in
);
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [12:0] LIE_MASK   = 13'h1BFF;
  localparam logic [TIMER_W-1:0] TVAL_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

  logic [1:0]         crmd_plv;
  logic               crmd_ie, crmd_da, crmd_pg;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         estat_is_sw;
  logic               estat_is_timer;
  logic [5:0]         estat_ecode;
  logic [8:0]         estat_esubcode;
  logic [31:0]        era, badv;
  logic [25:0]        eentry_va;
  logic [31:0]        save0, save1, save2, save3;
  logic [31:0]        tid, tcfg;
  logic [TIMER_W-1:0] tval;
  logic               timer_cnt;
  logic               has_int_q;

  logic [12:0] estat_is;
  logic [31:0] raw_val;
  logic [31:0] merged;
  logic        wr_en;
  logic        tcfg_wr;
  logic        ticlr_hit;
  logic        timer_fire;

  // Hardware and IPI lines are sampled straight into IS so has_int sees them one edge later.
  assign estat_is = {ipi_int_in, estat_is_timer, 1'b0, hw_int_in, estat_is_sw};

  always_comb begin
    raw_val = 32'h0;
    case (bus.csr_num)
      CSR_CRMD:   raw_val = {27'h0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
      CSR_PRMD:   raw_val = {29'h0, prmd_pie, prmd_pplv};
      CSR_ECFG:   raw_val = {19'h0, ecfg_lie};
      CSR_ESTAT:  raw_val = {1'b0, estat_esubcode, estat_ecode, 3'b000, estat_is};
      CSR_ERA:    raw_val = era;
      CSR_BADV:   raw_val = badv;
      CSR_EENTRY: raw_val = {eentry_va, 6'h0};
      CSR_SAVE0:  raw_val = save0;
      CSR_SAVE1:  raw_val = save1;
      CSR_SAVE2:  raw_val = save2;
      CSR_SAVE3:  raw_val = save3;
      CSR_TID:    raw_val = tid;
      CSR_TCFG:   raw_val = tcfg;
      CSR_TVAL:   raw_val = tval;
      default:    raw_val = 32'h0;
    endcase
  end

  assign merged     = (raw_val & ~bus.csr_wmask) | (bus.csr_wvalue & bus.csr_wmask);
  assign wr_en      = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
  assign tcfg_wr    = wr_en && (bus.csr_num == CSR_TCFG);
  assign ticlr_hit  = wr_en && (bus.csr_num == CSR_TICLR) && bus.csr_wmask[0] && bus.csr_wvalue[0];
  assign timer_fire = timer_cnt && (tval == '0);

  assign bus.csr_rvalue = bus.csr_re ? raw_val : 32'h0;
  assign bus.csr_era    = era;
  assign bus.csr_eentry = {eentry_va, 6'h0};
  assign bus.has_int    = has_int_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv       <= 2'b00;
      crmd_ie        <= 1'b0;
      crmd_da        <= 1'b1;
      crmd_pg        <= 1'b0;
      prmd_pplv      <= 2'b00;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= 13'h0;
      estat_is_sw    <= 2'b00;
      estat_is_timer <= 1'b0;
      estat_ecode    <= 6'h0;
      estat_esubcode <= 9'h0;
      era            <= 32'h0;
      badv           <= 32'h0;
      eentry_va      <= 26'h0;
      save0          <= 32'h0;
      save1          <= 32'h0;
      save2          <= 32'h0;
      save3          <= 32'h0;
      tid            <= TID_RESET;
      tcfg           <= 32'h0;
      tval           <= '0;
      timer_cnt      <= 1'b0;
      has_int_q      <= 1'b0;
    end else begin
      if (bus.wb_ex) begin
        prmd_pplv      <= crmd_plv;
        prmd_pie       <= crmd_ie;
        crmd_plv       <= 2'b00;
        crmd_ie        <= 1'b0;
        estat_ecode    <= bus.wb_ecode;
        estat_esubcode <= bus.wb_esubcode;
        era            <= bus.wb_pc;
        if (bus.wb_ecode == 6'h8 || bus.wb_ecode == 6'h9)
          badv <= bus.wb_vaddr;
      end else if (bus.ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (bus.csr_we) begin
        case (bus.csr_num)
          CSR_CRMD:   {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= merged[4:0];
          CSR_PRMD:   {prmd_pie, prmd_pplv} <= merged[2:0];
          CSR_ECFG:   ecfg_lie <= merged[12:0] & LIE_MASK;
          CSR_ESTAT:  estat_is_sw <= merged[1:0];
          CSR_ERA:    era <= merged;
          CSR_BADV:   badv <= merged;
          CSR_EENTRY: eentry_va <= merged[31:6];
          CSR_SAVE0:  save0 <= merged;
          CSR_SAVE1:  save1 <= merged;
          CSR_SAVE2:  save2 <= merged;
          CSR_SAVE3:  save3 <= merged;
          CSR_TID:    tid <= merged;
          CSR_TCFG:   tcfg <= merged;
          default: ;
        endcase
      end

      // A TCFG write restarts the counter even if it was mid-count or expiring this cycle.
      if (tcfg_wr) begin
        tval      <= {merged[31:2], 2'b00};
        timer_cnt <= merged[0];
      end else if (timer_cnt) begin
        if (tval != '0) begin
          tval <= tval - TVAL_ONE;
        end else if (tcfg[1]) begin
          tval <= {tcfg[31:2], 2'b00};
        end else begin
          tval      <= '1;
          timer_cnt <= 1'b0;
        end
      end

      if (timer_fire)
        estat_is_timer <= 1'b1;
      else if (ticlr_hit)
        estat_is_timer <= 1'b0;

      has_int_q <= (|(estat_is & ecfg_lie)) & crmd_ie;
    end
  end
endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed vector bench for csr_regfile
module tb_csr_regfile;
  logic       clk;
  logic       reset;
  logic [7:0] hw_int_in;
  logic       ipi_int_in;

  csr_regfile_if bus ();

  csr_regfile #(.TID_RESET(32'h0000_00A5), .TIMER_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] val;
    logic [13:0] rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_we     = 1'b1;
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    tick();
    bus.csr_we     = 1'b0;
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] val);
    bus.csr_re  = 1'b1;
    bus.csr_num = num;
    #1;
    val = bus.csr_rvalue;
  endtask

  task automatic rd_check(input string nm, input logic [13:0] num, input logic [31:0] exp);
    logic [31:0] v;
    rd(num, v);
    check(nm, v, exp);
  endtask

  task automatic is11_check(input string nm, input logic exp);
    logic [31:0] v;
    rd(14'h005, v);
    check(nm, {31'h0, v[11]}, {31'h0, exp});
  endtask

  initial begin
    logic [31:0] v;
    reset = 1'b1;
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;
    bus.csr_re = 1'b0;
    bus.csr_num = 14'h0;
    bus.csr_we = 1'b0;
    bus.csr_wmask = 32'h0;
    bus.csr_wvalue = 32'h0;
    bus.wb_ex = 1'b0;
    bus.wb_ecode = 6'h0;
    bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h0;
    bus.wb_vaddr = 32'h0;
    bus.ertn_flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_has_int", {31'h0, bus.has_int}, 32'h0);
    check("rst_era_out", bus.csr_era, 32'h0);
    check("rst_eentry_out", bus.csr_eentry, 32'h0);

    vecs.push_back('{1'b0, 14'h000, 32'h0,        32'h0,        14'h000, 32'h0000_0008});
    vecs.push_back('{1'b0, 14'h000, 32'h0,        32'h0,        14'h040, 32'h0000_00A5});
    vecs.push_back('{1'b0, 14'h000, 32'h0,        32'h0,        14'h041, 32'h0000_0000});
    vecs.push_back('{1'b0, 14'h000, 32'h0,        32'h0,        14'h042, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h000, 32'h7,        32'h7,        14'h000, 32'h0000_000F});
    vecs.push_back('{1'b1, 14'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h000, 32'h0000_001F});
    vecs.push_back('{1'b1, 14'h000, 32'h1F,       32'hF,        14'h000, 32'h0000_000F});
    vecs.push_back('{1'b1, 14'h001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h001, 32'h0000_0007});
    vecs.push_back('{1'b1, 14'h001, 32'hFFFF_FFFF, 32'h0,        14'h001, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h004, 32'h0000_1BFF});
    vecs.push_back('{1'b1, 14'h004, 32'hFFFF_FFFF, 32'h0,        14'h004, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h005, 32'h0000_0003});
    vecs.push_back('{1'b1, 14'h005, 32'hFFFF_FFFF, 32'h0,        14'h005, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h00C, 32'hFFFF_FFFF, 32'h1C00_803F, 14'h00C, 32'h1C00_8000});
    vecs.push_back('{1'b1, 14'h032, 32'hFFFF_0000, 32'hCAFE_BABE, 14'h032, 32'hCAFE_0000});
    vecs.push_back('{1'b1, 14'h033, 32'hFFFF_FFFF, 32'h1234_5678, 14'h033, 32'h1234_5678});
    vecs.push_back('{1'b1, 14'h040, 32'h0000_00FF, 32'h0000_0077, 14'h040, 32'h0000_0077});
    vecs.push_back('{1'b1, 14'h042, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h042, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h002, 32'h0000_0000});
    vecs.push_back('{1'b0, 14'h000, 32'h0,        32'h0,        14'h044, 32'h0000_0000});
    vecs.push_back('{1'b1, 14'h006, 32'hFFFF_FFFF, 32'h1C00_0000, 14'h006, 32'h1C00_0000});

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].num, vecs[i].mask, vecs[i].val);
      rd_check($sformatf("vec%0d", i), vecs[i].rd, vecs[i].exp);
    end
    check("eentry_out", bus.csr_eentry, 32'h1C00_8000);
    check("has_int_idle", {31'h0, bus.has_int}, 32'h0);

    bus.csr_re = 1'b0;
    bus.csr_num = 14'h000;
    #1;
    check("re_low", bus.csr_rvalue, 32'h0);

    // exception commit outranks a same-cycle SAVE0 write
    bus.wb_ex = 1'b1;
    bus.wb_ecode = 6'h9;
    bus.wb_esubcode = 9'h0;
    bus.wb_pc = 32'h1C00_0100;
    bus.wb_vaddr = 32'h0000_1234;
    bus.csr_we = 1'b1;
    bus.csr_num = 14'h030;
    bus.csr_wmask = 32'hFFFF_FFFF;
    bus.csr_wvalue = 32'h0000_DEAD;
    tick();
    bus.wb_ex = 1'b0;
    bus.csr_we = 1'b0;
    rd_check("ex_prmd", 14'h001, 32'h7);
    rd_check("ex_crmd", 14'h000, 32'h8);
    rd_check("ex_era", 14'h006, 32'h1C00_0100);
    rd_check("ex_badv", 14'h007, 32'h0000_1234);
    rd_check("ex_estat", 14'h005, 32'h0009_0000);
    rd_check("ex_save0", 14'h030, 32'h0);
    check("ex_era_out", bus.csr_era, 32'h1C00_0100);

    bus.ertn_flush = 1'b1;
    wr(14'h000, 32'h1F, 32'h0);
    bus.ertn_flush = 1'b0;
    rd_check("ertn_crmd", 14'h000, 32'hF);

    bus.wb_ex = 1'b1;
    bus.wb_ecode = 6'h3;
    bus.wb_esubcode = 9'h1;
    bus.wb_pc = 32'h1C00_0200;
    bus.wb_vaddr = 32'h0000_5555;
    tick();
    bus.wb_ex = 1'b0;
    rd_check("ex2_badv_kept", 14'h007, 32'h0000_1234);
    rd_check("ex2_era", 14'h006, 32'h1C00_0200);
    rd_check("ex2_estat", 14'h005, 32'h0043_0000);
    rd_check("ex2_crmd", 14'h000, 32'h8);
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
    rd_check("ertn2_crmd", 14'h000, 32'hF);

    hw_int_in = 8'h81;
    ipi_int_in = 1'b1;
    rd_check("hw_ipi_is", 14'h005, 32'h0043_1204);
    hw_int_in = 8'h0;
    ipi_int_in = 1'b0;

    // periodic timer: InitVal 2 -> counts 8..0 then reloads
    wr(14'h004, 32'hFFFF_FFFF, 32'h800);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
    rd_check("per_load", 14'h042, 32'h8);
    for (int i = 7; i >= 0; i--) begin
      tick();
      rd_check($sformatf("per_tval%0d", i), 14'h042, i);
    end
    is11_check("per_is11_pre", 1'b0);
    tick();
    is11_check("per_is11_set", 1'b1);
    rd_check("per_reload", 14'h042, 32'h8);
    check("per_int_lat", {31'h0, bus.has_int}, 32'h0);
    tick();
    check("per_int_rise", {31'h0, bus.has_int}, 32'h1);
    rd_check("per_tval_7", 14'h042, 32'h7);

    // one-shot timer then TICLR
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
    rd_check("one_load", 14'h042, 32'h8);
    for (int i = 7; i >= 0; i--) begin
      tick();
      rd_check($sformatf("one_tval%0d", i), 14'h042, i);
    end
    tick();
    rd_check("one_expired", 14'h042, 32'hFFFF_FFFF);
    tick();
    rd_check("one_hold", 14'h042, 32'hFFFF_FFFF);
    is11_check("one_is11", 1'b1);
    check("one_int", {31'h0, bus.has_int}, 32'h1);
    wr(14'h044, 32'h1, 32'h1);
    is11_check("ticlr_is11", 1'b0);
    check("ticlr_int_lat", {31'h0, bus.has_int}, 32'h1);
    tick();
    check("ticlr_int_fall", {31'h0, bus.has_int}, 32'h0);

    // TICLR coincident with expiry: the set wins
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0001);
    rd_check("zero_load", 14'h042, 32'h0);
    is11_check("zero_is11_pre", 1'b0);
    wr(14'h044, 32'h1, 32'h1);
    is11_check("ticlr_vs_fire", 1'b1);
    rd_check("zero_expired", 14'h042, 32'hFFFF_FFFF);

    // reset in the middle of a count
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
    tick();
    tick();
    rd_check("mid_tval", 14'h042, 32'h6);
    check("mid_int", {31'h0, bus.has_int}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_check("rst2_tval", 14'h042, 32'h0);
    rd_check("rst2_tcfg", 14'h041, 32'h0);
    rd_check("rst2_estat", 14'h005, 32'h0);
    rd_check("rst2_crmd", 14'h000, 32'h8);
    check("rst2_int", {31'h0, bus.has_int}, 32'h0);
    check("rst2_era_out", bus.csr_era, 32'h0);
    tick();
    rd_check("rst2_tval_hold", 14'h042, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Control/status register file for the LoongArch pipeline.
- It is the responder to the writeback stage's CSR access and exception-commit interface. It serves csrrd/csrwr/csrxchg reads and masked writes, records exception state on commit, and restores state on ertn.
- It runs the stable counter timer and aggregates interrupt sources into a single has_int flag. The decode stage tags that flag onto the next instruction.

Parameters:
- TID_RESET, 32'h0, reset value of the TID register (core timer ID).
- TIMER_W, 32, width of the TVAL down-counter. Only 32 is supported.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- csr_re, input, 1, read enable; csr_rvalue is 0 when low.
- csr_num, input, 14, CSR address for read and write.
- csr_rvalue, output, 32, combinational read data of the addressed CSR.
- csr_we, input, 1, write enable.
- csr_wmask, input, 32, per-bit write mask.
- csr_wvalue, input, 32, write data.
- wb_ex, input, 1, exception commit strobe, one cycle.
- wb_ecode, input, 6, exception code.
- wb_esubcode, input, 9, exception subcode.
- wb_pc, input, 32, PC of the faulting instruction.
- wb_vaddr, input, 32, bad virtual address.
- ertn_flush, input, 1, ertn commit strobe.
- hw_int_in, input, 8, hardware interrupt lines, level-sampled each cycle.
- ipi_int_in, input, 1, inter-processor interrupt line, level-sampled.
- csr_eentry, output, 32, exception entry address: {EENTRY[31:6], 6'b0}.
- csr_era, output, 32, ERA register, used directly as the ertn target.
- has_int, output, 1, enabled interrupt is pending.

Behaviour:

Implemented registers (number: fields; any other number reads 0 and writes are ignored):
- 0x0 CRMD: PLV[1:0], IE[2], DA[3], PG[4]; other bits read 0.
- 0x1 PRMD: PPLV[1:0], PIE[2].
- 0x4 ECFG: LIE[9:0], LIE[12:11].
- 0x5 ESTAT:
  - IS[1:0] is software-writable.
  - IS[9:2] follows hw_int_in every cycle.
  - IS[11] is the timer interrupt.
  - IS[12] follows ipi_int_in every cycle.
  - Ecode[21:16] and EsubCode[30:22] are read-only to software.
- 0x6 ERA.
- 0x7 BADV.
- 0xC EENTRY: VA[31:6]; bits [5:0] read 0.
- 0x30-0x33 SAVE0-3.
- 0x40 TID.
- 0x41 TCFG: En[0], Periodic[1], InitVal[31:2].
- 0x42 TVAL: read-only.
- 0x44 TICLR: write-only; reads 0.

Reset values:
- CRMD = 32'h8 (DA=1).
- TID = TID_RESET.
- All other registers = 0, including TCFG.En = 0 and TVAL = 0.
- Outputs: has_int = 0, csr_era = 0, csr_eentry = 0.

Write rule:
- new = (old & ~wmask) | (wvalue & wmask), applied only to writable bits, on the clock edge.
- Reads are combinational and return pre-edge state, so csrxchg returns the old value.

Exception commit (wb_ex = 1):
- PRMD.PPLV <= CRMD.PLV and PRMD.PIE <= CRMD.IE.
- CRMD.PLV <= 0 and CRMD.IE <= 0.
- ESTAT.Ecode <= wb_ecode and ESTAT.EsubCode <= wb_esubcode.
- ERA <= wb_pc.
- BADV <= wb_vaddr only when wb_ecode is 0x8 (ADEF) or 0x9 (ALE).

ertn (ertn_flush = 1, wb_ex = 0):
- CRMD.PLV <= PRMD.PPLV and CRMD.IE <= PRMD.PIE.

Same-cycle priority:
- wb_ex over ertn_flush over csr_we. The lower-priority action is dropped entirely.

Timer:
- Writing TCFG loads TVAL <= {InitVal, 2'b00} on the same edge and sets an internal counting flag to the written En.
- While counting and TVAL != 0: TVAL decrements by 1 per cycle.
- On the cycle TVAL == 0 while counting: ESTAT.IS[11] <= 1.
  - Periodic = 1: TVAL reloads to {InitVal, 2'b00}.
  - Periodic = 0: TVAL <= 32'hFFFFFFFF and counting stops.
- A TVAL of 0 with En = 0 never sets IS[11].

TICLR:
- A write with wvalue[0] & wmask[0] = 1 clears ESTAT.IS[11].
- If the timer sets IS[11] on the same edge, the set wins.

has_int:
- Registered: has_int <= |(ESTAT.IS[12:0] & ECFG.LIE[12:0]) & CRMD.IE.
- This gives one cycle of latency from any source change.
- Reset mid-timer clears the counting flag and IS[11] immediately.

Test Plan:
1. Write CRMD with mask 0x7, value 0x7 -> next cycle CRMD reads 0xF; has_int stays 0 with ECFG = 0.
2. CRMD = 0x7, wb_ex with ecode 0x9, pc 0x1C000100, vaddr 0x1234 ->
   - PRMD reads 0x7, CRMD reads 0x8, ERA = 0x1C000100, BADV = 0x1234, ESTAT[21:16] = 0x9.
   - Then ertn_flush -> CRMD reads 0xF.
3. TCFG = 0x0000000B (InitVal 2, periodic, En) -> TVAL reads 8,7,...,0.
   - IS[11] sets the cycle after TVAL == 0; TVAL reloads to 8.
   - With ECFG.LIE[11] = 1 and CRMD.IE = 1, has_int rises one cycle after IS[11].
4. Non-periodic TCFG = 0x9 -> TVAL counts 8..0, then reads 0xFFFFFFFF and holds.
   - TICLR write 1 -> IS[11] = 0; has_int falls one cycle later.
5. Same-cycle wb_ex and csr_we to SAVE0 = 0xDEAD -> SAVE0 unchanged and ERA updated.
   - Same-cycle TICLR and timer expiry -> IS[11] = 1.
6. Read csr_num 0x2 (unmapped) and TICLR -> 0. csr_re = 0 -> csr_rvalue = 0.
   - Assert reset mid-count -> TVAL, TCFG, IS[11] and has_int are 0 next cycle.
